// File: rtl/fd_pipe_reg.sv
// Fetch/decode pipeline register.
// Turns faulting fetches into NOPs tagged with AdEL.
module fd_pipe_reg #(
  parameter logic [31:0] TEXT_BASE  = 32'h0000_3000,
  parameter logic [31:0] TEXT_END   = 32'h0000_6FFC,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
  parameter logic [31:0] NOP        = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        stall_md,
  input  logic        int_req,
  input  logic        eret_clr,
  input  logic [31:0] pc_f,
  input  logic [31:0] ir_f,
  input  logic        is_bd_f,
  output logic [31:0] pc_d,
  output logic [31:0] ir_d,
  output logic [4:0]  exc_code_d,
  output logic        is_bd_d,
  output logic        valid_d
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  logic misaligned;
  logic out_of_range;
  logic fault;
  logic hold;

  assign misaligned   = pc_f[1:0] != 2'b00;
  assign out_of_range = (pc_f < TEXT_BASE) || (pc_f > TEXT_END);
  assign fault        = misaligned || out_of_range;
  assign hold         = !en || stall_md;

  // Flushes override the stall so the PC register and this stage agree.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_d       <= TEXT_BASE;
      ir_d       <= NOP;
      exc_code_d <= EXC_NONE;
      is_bd_d    <= 1'b0;
      valid_d    <= 1'b0;
    end else if (int_req) begin
      pc_d       <= HANDLER_PC;
      ir_d       <= NOP;
      exc_code_d <= EXC_NONE;
      is_bd_d    <= 1'b0;
      valid_d    <= 1'b0;
    end else if (eret_clr) begin
      pc_d       <= pc_f;
      ir_d       <= NOP;
      exc_code_d <= EXC_NONE;
      is_bd_d    <= 1'b0;
      valid_d    <= 1'b0;
    end else if (!hold) begin
      pc_d       <= pc_f;
      ir_d       <= fault ? NOP : ir_f;
      exc_code_d <= fault ? EXC_ADEL : EXC_NONE;
      is_bd_d    <= is_bd_f;
      valid_d    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Scoreboard bench for fd_pipe_reg.
// Directed scenarios followed by randomized traffic.
module tb_fd_pipe_reg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [4:0]  exc;
    logic        bd;
    logic        v;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b1;
  logic        stall_md = 1'b0;
  logic        int_req = 1'b0;
  logic        eret_clr = 1'b0;
  logic [31:0] pc_f = 32'h3000;
  logic [31:0] ir_f = 32'h0;
  logic        is_bd_f = 1'b0;
  logic [31:0] pc_d;
  logic [31:0] ir_d;
  logic [4:0]  exc_code_d;
  logic        is_bd_d;
  logic        valid_d;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];
  exp_t model_q;

  fd_pipe_reg dut (
    .clk(clk), .reset(reset), .en(en), .stall_md(stall_md),
    .int_req(int_req), .eret_clr(eret_clr),
    .pc_f(pc_f), .ir_f(ir_f), .is_bd_f(is_bd_f),
    .pc_d(pc_d), .ir_d(ir_d), .exc_code_d(exc_code_d),
    .is_bd_d(is_bd_d), .valid_d(valid_d)
  );

  always #5 clk = ~clk;

  // Reference: what decode should see after the edge, from the rules.
  function automatic exp_t predict(exp_t cur, logic rs, logic e,
                                   logic md, logic irq, logic er,
                                   logic [31:0] pc, logic [31:0] ir,
                                   logic bd);
    exp_t n;
    longint unsigned a;
    bit legal;
    a = pc;
    legal = (a % 4 == 0) && (a >= 64'h3000) && (a <= 64'h6FFC);
    if (rs)             n = '{32'h3000, 32'h0, 5'd0, 1'b0, 1'b0};
    else if (irq)       n = '{32'h4180, 32'h0, 5'd0, 1'b0, 1'b0};
    else if (er)        n = '{pc, 32'h0, 5'd0, 1'b0, 1'b0};
    else if (!e || md)  n = cur;
    else if (legal)     n = '{pc, ir, 5'd0, bd, 1'b1};
    else                n = '{pc, 32'h0, 5'd4, bd, 1'b1};
    return n;
  endfunction

  task automatic step(input logic rs, input logic e, input logic md,
                      input logic irq, input logic er,
                      input logic [31:0] pc, input logic [31:0] ir,
                      input logic bd);
    @(negedge clk);
    reset = rs; en = e; stall_md = md; int_req = irq; eret_clr = er;
    pc_f = pc; ir_f = ir; is_bd_f = bd;
    model_q = predict(model_q, rs, e, md, irq, er, pc, ir, bd);
    sb.push_back(model_q);
  endtask

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        cmp("pc_d", pc_d, e.pc);
        cmp("ir_d", ir_d, e.ir);
        cmp("exc_code_d", {27'd0, exc_code_d}, {27'd0, e.exc});
        cmp("is_bd_d", {31'd0, is_bd_d}, {31'd0, e.bd});
        cmp("valid_d", {31'd0, valid_d}, {31'd0, e.v});
      end
    end
  end

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 7))
      0: return 32'h2FFC;
      1: return 32'h3000;
      2: return 32'h6FFC;
      3: return 32'h7000;
      4: return 32'h3000 + ($urandom_range(0, 32'h0FFF) << 2);
      5: return 32'h3000 + $urandom_range(0, 32'h3FFF);
      6: return $urandom;
      default: return 32'hFFFF_FFFC;
    endcase
  endfunction

  initial begin : stim
    model_q = '{32'h3000, 32'h0, 5'd0, 1'b0, 1'b0};
    step(1, 1, 0, 0, 0, 32'h3000, 32'h3C01_0001, 0);
    step(1, 1, 0, 0, 0, 32'h3000, 32'h3C01_0001, 0);
    step(0, 1, 0, 0, 0, 32'h3000, 32'h3C01_0001, 0);
    step(0, 1, 0, 0, 0, 32'h3004, 32'h2421_0005, 0);
    step(0, 0, 0, 0, 0, 32'h3008, 32'h1111_1111, 0);
    step(0, 0, 0, 0, 0, 32'h300C, 32'h2222_2222, 1);
    step(0, 0, 0, 0, 0, 32'h3010, 32'h3333_3333, 0);
    step(0, 1, 0, 0, 0, 32'h3014, 32'h4444_4444, 0);
    step(0, 1, 0, 0, 0, 32'h3006, 32'h5555_5555, 0);
    step(0, 1, 0, 0, 0, 32'h7000, 32'hFFFF_FFFF, 1);
    step(0, 1, 0, 0, 0, 32'h6FFC, 32'h0000_0001, 0);
    step(0, 1, 0, 0, 0, 32'h2FFC, 32'h0000_0002, 0);
    step(0, 1, 0, 0, 0, 32'h3010, 32'h0000_0003, 1);
    step(0, 1, 1, 1, 0, 32'h3014, 32'h0000_0004, 1);
    step(0, 1, 1, 0, 0, 32'h3018, 32'h0000_0005, 0);
    step(0, 1, 0, 0, 1, 32'h3020, 32'h0000_0020, 1);
    step(0, 1, 0, 1, 1, 32'h3024, 32'h0000_0021, 0);
    step(0, 1, 0, 0, 0, 32'h3001, 32'h0000_0022, 0);
    step(0, 0, 0, 0, 0, 32'h3028, 32'h0000_0023, 0);
    step(0, 0, 0, 0, 0, 32'h302C, 32'h0000_0024, 0);
    step(1, 0, 0, 0, 0, 32'h3030, 32'h0000_0025, 0);
    step(0, 1, 0, 0, 0, 32'h3030, 32'h0000_0026, 0);
    for (int i = 0; i < 2000; i++) begin
      step($urandom_range(0, 39) == 0,
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 14) == 0,
           $urandom_range(0, 11) == 0,
           rand_pc(), $urandom, 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fd_pipe_reg.md
Name: fd_pipe_reg

Overview:
- Fetch/Decode pipeline register of the 5-stage MIPS core.
- Captures the fetched PC, instruction and delay-slot flag from the fetch stage and presents them to decode.
- Detects fetch address exceptions (AdEL) and converts the faulting fetch into a NOP carrying ExcCode 4.
- Supports stall (hold), interrupt flush and eret flush, using the same advance conditions as the PC register.

Parameters:
- TEXT_BASE, 32'h0000_3000, lowest legal instruction address; also the reset value of pc_d.
- TEXT_END, 32'h0000_6FFC, highest legal instruction address (inclusive).
- HANDLER_PC, 32'h0000_4180, PC value loaded into pc_d on an interrupt flush.
- NOP, 32'h0000_0000, instruction word injected on a flush or fetch exception.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- en  in  1  hazard-unit enable; 0 = stall.
- stall_md  in  1  mult/div busy stall; 1 = stall.
- int_req  in  1  CP0 interrupt/exception request; flushes the stage.
- eret_clr  in  1  eret in decode; flushes the wrong-path fetch.
- pc_f  in  32  fetch-stage PC.
- ir_f  in  32  instruction word read from instruction memory at pc_f.
- is_bd_f  in  1  1 = the fetched instruction is in a branch/jump delay slot.
- pc_d  out  32  decode-stage PC.
- ir_d  out  32  decode-stage instruction.
- exc_code_d  out  5  pending exception code: 0 = none, 4 = AdEL.
- is_bd_d  out  1  delay-slot flag for decode.
- valid_d  out  1  1 = slot holds a real instruction (including a faulting one); 0 = bubble.

Behaviour:
- All state updates on the rising edge of clk. Outputs come straight from registers; there is no combinational path from input to output.
- Reset values: pc_d=TEXT_BASE, ir_d=NOP, exc_code_d=0, is_bd_d=0, valid_d=0.
- Update priority per cycle, highest first:
  1. reset → reset values.
  2. int_req → interrupt flush: pc_d=HANDLER_PC, ir_d=NOP, exc_code_d=0, is_bd_d=0, valid_d=0.
  3. eret_clr → eret flush: pc_d=pc_f, ir_d=NOP, exc_code_d=0, is_bd_d=0, valid_d=0.
  4. Stall, when en=0 or stall_md=1 → every output holds its value.
  5. Otherwise → load.
- Load with a legal address, where pc_f[1:0]==0 and TEXT_BASE<=pc_f<=TEXT_END:
  - pc_d=pc_f, ir_d=ir_f, exc_code_d=0, is_bd_d=is_bd_f, valid_d=1.
- Load with an illegal address (misaligned or outside the range):
  - pc_d=pc_f, ir_d=NOP, exc_code_d=5'd4, is_bd_d=is_bd_f, valid_d=1.
  - ir_f is ignored in this case.
- Range compare is unsigned 32-bit. Both boundaries are inclusive: TEXT_END is legal, TEXT_END+4 faults.
- Misalignment takes precedence over the range check only for reporting purposes. The code is the same (4) in both cases.
- A flush forces is_bd_d=0, even when is_bd_f=1.
- A stall holds a pending exc_code_d, so the exception is neither lost nor duplicated.
- int_req together with a stall: the flush wins (int_req overrides the stall), matching the PC register update rule.
- int_req together with eret_clr: the int_req flush wins.
- reset asserted mid-stall or mid-flush: reset values are loaded on the next edge, with no residual state.
- Latency: one cycle from F to D. One instruction per cycle when not stalled.

Test Plan:
- Assert reset for 2 cycles, then release with en=1, pc_f=0x3000, ir_f=0x3C010001 → after reset pc_d=0x3000, ir_d=0, valid_d=0; on the next edge ir_d=0x3C010001, valid_d=1, exc_code_d=0.
- Load pc_f=0x3004, ir_f=0x24210005, then hold en=0 for 3 cycles while pc_f/ir_f change → pc_d=0x3004 and ir_d=0x24210005 throughout; the new values load on the cycle after en returns to 1.
- pc_f=0x3006 in one case, and pc_f=0x7000 with ir_f=0xFFFFFFFF in another → each gives ir_d=0, exc_code_d=4, valid_d=1; pc_f=0x6FFC loads normally with exc_code_d=0.
- Load pc_f=0x3010 with is_bd_f=1, then assert int_req together with stall_md=1 → pc_d=0x4180, ir_d=0, is_bd_d=0, valid_d=0 on that edge.
- eret_clr=1 with pc_f=0x3020 and ir_f=0x00000020 → pc_d=0x3020, ir_d=0, valid_d=0; assert int_req and eret_clr together → pc_d=0x4180.
- Load a faulting pc_f=0x3001, then apply en=0 for 2 cycles → exc_code_d stays 4 and pc_d stays 0x3001; assert reset during the stall → exc_code_d=0, pc_d=0x3000.
